multicycle_control: RTL and testbench

Multi-cycle sequencer for the MIPS datapath. It replaces single-cycle decode with a Moore state machine that steps each instruction through fetch, decode, execute, memory and write-back. It drives every datapath mux select and write enable, and stalls on a shared instruction/data memory through a `mem_ready` handshake. It decodes the team ISA (R-type 0, LW 4, SW 5, BEQ 6, J 2, JAL 3) and counts retired instructions.

---
 rtl/multicycle_control.sv | 195 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control sequencer: steps each instruction through fetch, decode,
// execute, memory and write-back, and drives every datapath select and write enable.
// Outputs are combinational from state/opcode/mem_ready; FETCH, MEM_READ and MEM_WRITE
// hold until mem_ready.
// Ports: clk, reset (sync, active-low), opcode/zero/mem_ready in; datapath controls,
// instr_done/illegal_op pulses, state and instr_count out.
module multicycle_control #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IorD,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic [1:0]       PCSource,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             RegDst,
    output logic             MemToReg,
    output logic             RegWrite,
    output logic             Jal,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [WIDTH-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9
    } state_t;

    localparam logic [5:0] OP_R   = 6'd0;
    localparam logic [5:0] OP_J   = 6'd2;
    localparam logic [5:0] OP_JAL = 6'd3;
    localparam logic [5:0] OP_LW  = 6'd4;
    localparam logic [5:0] OP_SW  = 6'd5;
    localparam logic [5:0] OP_BEQ = 6'd6;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] instr_count_q, instr_count_d;

    // The branch decision is made in the datapath (zero AND PCWriteCond).
    logic unused_zero;
    assign unused_zero = zero;

    always_comb begin
        state_d     = state_q;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        RegDst      = 1'b0;
        MemToReg    = 1'b0;
        RegWrite    = 1'b0;
        Jal         = 1'b0;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_R:          state_d = S_EXEC_R;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_J, OP_JAL:  state_d = S_JUMP;
                    default: begin
                        // Unknown opcodes retire immediately so the count stays in step with fetches.
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                MemToReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = S_R_WB;
            end
            S_R_WB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
                if (opcode == OP_JAL) begin
                    RegWrite = 1'b1;
                    Jal      = 1'b1;
                end
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset kills any in-flight request in the same cycle it is asserted.
        if (!reset) begin
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IorD        = 1'b0;
            IRWrite     = 1'b0;
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            PCSource    = 2'b00;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            ALUOp       = 2'b00;
            RegDst      = 1'b0;
            MemToReg    = 1'b0;
            RegWrite    = 1'b0;
            Jal         = 1'b0;
            instr_done  = 1'b0;
            illegal_op  = 1'b0;
        end

        instr_count_d = instr_done ? instr_count_q + WIDTH'(1) : instr_count_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_FETCH;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign state       = state_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle expected state, control vector
// and retired count are queued when each cycle is driven and compared at the negedge.
// A second instance with a 4-bit counter shares all inputs to exercise counter wrap.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    always #5 clk = ~clk;

    // Control vector: {MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, PCSource,
    //                  ALUSrcA, ALUSrcB, ALUOp, RegDst, MemToReg, RegWrite, Jal,
    //                  instr_done, illegal_op}
    typedef logic [18:0] ctrl_t;

    logic        a_MemRead, a_MemWrite, a_IorD, a_IRWrite, a_PCWrite, a_PCWriteCond;
    logic [1:0]  a_PCSource, a_ALUSrcB, a_ALUOp;
    logic        a_ALUSrcA, a_RegDst, a_MemToReg, a_RegWrite, a_Jal, a_done, a_ill;
    logic [3:0]  a_state;
    logic [31:0] a_count;

    logic        b_MemRead, b_MemWrite, b_IorD, b_IRWrite, b_PCWrite, b_PCWriteCond;
    logic [1:0]  b_PCSource, b_ALUSrcB, b_ALUOp;
    logic        b_ALUSrcA, b_RegDst, b_MemToReg, b_RegWrite, b_Jal, b_done, b_ill;
    logic [3:0]  b_state;
    logic [3:0]  b_count;

    multicycle_control #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .MemRead(a_MemRead), .MemWrite(a_MemWrite), .IorD(a_IorD), .IRWrite(a_IRWrite),
        .PCWrite(a_PCWrite), .PCWriteCond(a_PCWriteCond), .PCSource(a_PCSource),
        .ALUSrcA(a_ALUSrcA), .ALUSrcB(a_ALUSrcB), .ALUOp(a_ALUOp), .RegDst(a_RegDst),
        .MemToReg(a_MemToReg), .RegWrite(a_RegWrite), .Jal(a_Jal), .instr_done(a_done),
        .illegal_op(a_ill), .state(a_state), .instr_count(a_count)
    );

    multicycle_control #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .MemRead(b_MemRead), .MemWrite(b_MemWrite), .IorD(b_IorD), .IRWrite(b_IRWrite),
        .PCWrite(b_PCWrite), .PCWriteCond(b_PCWriteCond), .PCSource(b_PCSource),
        .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB), .ALUOp(b_ALUOp), .RegDst(b_RegDst),
        .MemToReg(b_MemToReg), .RegWrite(b_RegWrite), .Jal(b_Jal), .instr_done(b_done),
        .illegal_op(b_ill), .state(b_state), .instr_count(b_count)
    );

    ctrl_t a_ctrl, b_ctrl;
    assign a_ctrl = {a_MemRead, a_MemWrite, a_IorD, a_IRWrite, a_PCWrite, a_PCWriteCond,
                     a_PCSource, a_ALUSrcA, a_ALUSrcB, a_ALUOp, a_RegDst, a_MemToReg,
                     a_RegWrite, a_Jal, a_done, a_ill};
    assign b_ctrl = {b_MemRead, b_MemWrite, b_IorD, b_IRWrite, b_PCWrite, b_PCWriteCond,
                     b_PCSource, b_ALUSrcA, b_ALUSrcB, b_ALUOp, b_RegDst, b_MemToReg,
                     b_RegWrite, b_Jal, b_done, b_ill};

    typedef struct packed {
        logic [3:0]  st;
        ctrl_t       ctrl;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_cnt = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected controls straight from the per-state table of the control specification.
    function automatic ctrl_t exp_ctrl(input logic [3:0] st, input logic [5:0] op, input logic rdy);
        logic mr, mw, iord, irw, pcw, pcwc, srca, rdst, m2r, rw, jal, done, ill;
        logic [1:0] pcs, srcb, aop;
        {mr, mw, iord, irw, pcw, pcwc, srca, rdst, m2r, rw, jal, done, ill} = '0;
        pcs = 2'b00; srcb = 2'b00; aop = 2'b00;
        case (st)
            4'd0: begin mr = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
            4'd1: begin
                srcb = 2'b11;
                if (!(op inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6})) begin ill = 1; done = 1; end
            end
            4'd2: begin srca = 1; srcb = 2'b10; end
            4'd3: begin mr = 1; iord = 1; end
            4'd4: begin m2r = 1; rw = 1; done = 1; end
            4'd5: begin mw = 1; iord = 1; done = rdy; end
            4'd6: begin srca = 1; aop = 2'b10; end
            4'd7: begin rdst = 1; rw = 1; done = 1; end
            4'd8: begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
            4'd9: begin pcw = 1; pcs = 2'b10; done = 1; if (op == 6'd3) begin rw = 1; jal = 1; end end
            default: ;
        endcase
        return {mr, mw, iord, irw, pcw, pcwc, pcs, srca, srcb, aop, rdst, m2r, rw, jal, done, ill};
    endfunction

    // One clock cycle: drive inputs just after posedge, queue expectation, compare at negedge.
    task automatic step(input logic [3:0] st, input logic [5:0] op, input logic rdy);
        exp_t e, g;
        ctrl_t c;
        reset     = 1'b1;
        opcode    = op;
        mem_ready = rdy;
        zero      = 1'($urandom_range(1));
        c = exp_ctrl(st, op, rdy);
        e.st = st; e.ctrl = c; e.cnt = exp_cnt;
        sb_q.push_back(e);
        @(negedge clk);
        g = sb_q.pop_front();
        check_val($sformatf("state op%0d", op), 64'(a_state), 64'(g.st));
        check_val($sformatf("ctrl st%0d op%0d", g.st, op), 64'(a_ctrl), 64'(g.ctrl));
        check_val($sformatf("count st%0d", g.st), 64'(a_count), 64'(g.cnt));
        check_val($sformatf("ctrl4 st%0d", g.st), 64'(b_ctrl), 64'(g.ctrl));
        check_val($sformatf("count4 st%0d", g.st), 64'(b_count), 64'(g.cnt[3:0]));
        if (c[1]) exp_cnt = exp_cnt + 1;
        @(posedge clk); #1;
    endtask

    function automatic logic rb();
        return 1'($urandom_range(1));
    endfunction

    // Full instruction: fw wait cycles in FETCH, mw wait cycles in MEM_READ/MEM_WRITE.
    task automatic do_instr(input logic [5:0] op, input int fw, input int mw);
        for (int i = 0; i < fw; i++) step(4'd0, op, 1'b0);
        step(4'd0, op, 1'b1);
        step(4'd1, op, rb());
        case (op)
            6'd0: begin step(4'd6, op, rb()); step(4'd7, op, rb()); end
            6'd4: begin
                step(4'd2, op, rb());
                for (int i = 0; i < mw; i++) step(4'd3, op, 1'b0);
                step(4'd3, op, 1'b1);
                step(4'd4, op, rb());
            end
            6'd5: begin
                step(4'd2, op, rb());
                for (int i = 0; i < mw; i++) step(4'd5, op, 1'b0);
                step(4'd5, op, 1'b1);
            end
            6'd6: step(4'd8, op, rb());
            6'd2, 6'd3: step(4'd9, op, rb());
            default: ;
        endcase
    endtask

    // Hold reset low for n cycles with random inputs; outputs must be dead throughout.
    task automatic hold_reset(input int n);
        for (int i = 0; i < n; i++) begin
            reset     = 1'b0;
            opcode    = 6'($urandom_range(63));
            mem_ready = rb();
            zero      = rb();
            @(negedge clk);
            check_val("rst ctrl", 64'(a_ctrl), 64'd0);
            check_val("rst ctrl4", 64'(b_ctrl), 64'd0);
            @(posedge clk); #1;
            check_val("rst state", 64'(a_state), 64'd0);
            check_val("rst count", 64'(a_count), 64'd0);
        end
        exp_cnt = 0;
    endtask

    initial begin
        @(posedge clk); #1;
        hold_reset(3);

        // R-type with one FETCH stall, then LW with two MEM_READ stalls
        do_instr(6'd0, 1, 0);
        do_instr(6'd4, 0, 2);
        // SW then BEQ back-to-back, JAL, J, then illegal opcode
        do_instr(6'd5, 0, 1);
        do_instr(6'd6, 0, 0);
        do_instr(6'd3, 0, 0);
        do_instr(6'd2, 2, 0);
        do_instr(6'b111111, 0, 0);
        do_instr(6'd7, 0, 0);
        check_val("count after mix", 64'(a_count), 64'd8);

        // Reset asserted while SW is stalled in MEM_WRITE
        step(4'd0, 6'd5, 1'b1);
        step(4'd1, 6'd5, 1'b1);
        step(4'd2, 6'd5, 1'b0);
        step(4'd5, 6'd5, 1'b0);
        hold_reset(1);

        // 16 retirements wrap the 4-bit counter back to zero
        for (int i = 0; i < 16; i++) do_instr(6'($urandom_range(1) ? 0 : 6), 0, 0);
        check_val("wrap count4", 64'(b_count), 64'd0);
        check_val("count32 16", 64'(a_count), 64'd16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
